arpeggiator: RTL

- Note sequencer that sits directly upstream of one voice. It drives that voice's note and gate inputs.
- Keeps a small ascending-sorted table of currently held MIDI keys.
- Steps through the table at a programmable rate in the samples domain, using one of four patterns.
- Produces one note per step with a programmable gate length.

---
 rtl/arpeggiator_if.sv | 27 ++
 rtl/arpeggiator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/arpeggiator_if.sv
// Key-input, pattern-control and voice-output bundle for the arpeggiator.
// The master side supplies keys and settings; the slave side is the arpeggiator.
interface arpeggiator_if #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned RATE_WIDTH = 16
);
    logic [6:0]                     key_note;
    logic                           key_on;
    logic                           key_off;
    logic [1:0]                     mode;
    logic [RATE_WIDTH-1:0]          step_period;
    logic [RATE_WIDTH-1:0]          gate_length;
    logic [6:0]                     note;
    logic                           gate;
    logic [$clog2(NUM_SLOTS+1)-1:0] held_count;
    logic                           full;

    modport master (
        output key_note, key_on, key_off, mode, step_period, gate_length,
        input  note, gate, held_count, full
    );

    modport slave (
        input  key_note, key_on, key_off, mode, step_period, gate_length,
        output note, gate, held_count, full
    );
endinterface

// File: rtl/arpeggiator.sv
// Arpeggiator: sorted held-key table stepped through up/down/up-down/two-octave patterns.
// Define ARP_LATCH_EN to add i_latch, which holds released keys until latch drops.
module arpeggiator #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned RATE_WIDTH = 16
) (
    input  logic         sample_clock,
    input  logic         rst,
`ifdef ARP_LATCH_EN
    input  logic         i_latch,
`endif
    arpeggiator_if.slave arp
);
    localparam int unsigned CountWidth = $clog2(NUM_SLOTS + 1);
    localparam int unsigned IdxWidth   = $clog2(NUM_SLOTS);

    typedef enum logic {StIdle, StRun} state_e;

    logic [6:0]            r_table [NUM_SLOTS];
    logic [CountWidth-1:0] r_count;
    state_e                r_state;
    logic [RATE_WIDTH-1:0] r_counter;
    logic [IdxWidth-1:0]   r_idx;
    logic                  r_oct, r_dir;
    logic [1:0]            r_prev_mode;
    logic [6:0]            r_note;
    logic                  r_gate;

    logic [6:0]            w_table_next [NUM_SLOTS];
    logic [CountWidth-1:0] w_count_next;
    state_e                w_state_next;
    logic [RATE_WIDTH-1:0] w_counter_next;
    logic [IdxWidth-1:0]   w_idx_next;
    logic                  w_oct_next, w_dir_next, w_updn_dir;
    logic [1:0]            w_prev_mode_next;
    logic [6:0]            w_note_next, w_sel;
    logic                  w_gate_next;
    logic [31:0]           w_n, w_ins, w_hit_idx, w_p, w_g, w_cnt, w_idx, w_nxt, w_sum;
    logic                  w_hit, w_full, w_do_off, w_clear;

    assign w_n    = 32'(r_count);
    assign w_full = (r_count == CountWidth'(NUM_SLOTS));
    assign w_p    = (arp.step_period == '0) ? 32'd1 : 32'(arp.step_period);
    assign w_g    = (arp.gate_length == '0) ? 32'd1 : 32'(arp.gate_length);
    assign w_cnt  = 32'(r_counter);
    assign w_idx  = 32'(r_idx);

`ifdef ARP_LATCH_EN
    logic r_latch;
    assign w_do_off = arp.key_off && !i_latch;
    assign w_clear  = r_latch && !i_latch;
    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) r_latch <= 1'b0;
        else     r_latch <= i_latch;
    end
`else
    assign w_do_off = arp.key_off;
    assign w_clear  = 1'b0;
`endif

    // Insert position is the number of valid entries below the key.
    always_comb begin
        w_ins     = '0;
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (32'(i) < w_n) begin
                if (r_table[i] < arp.key_note) w_ins = w_ins + 32'd1;
                if (r_table[i] == arp.key_note) begin
                    w_hit     = 1'b1;
                    w_hit_idx = 32'(i);
                end
            end
        end
    end

    always_comb begin
        w_table_next = r_table;
        w_count_next = r_count;
        if (w_clear) begin
            w_count_next = '0;
        end else if (w_do_off) begin
            if (w_hit) begin
                for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                    if (32'(i) >= w_hit_idx) w_table_next[i] = r_table[i+1];
                end
                w_table_next[NUM_SLOTS-1] = '0;
                w_count_next = r_count - CountWidth'(1);
            end
        end else if (arp.key_on && !w_hit && !w_full) begin
            if (w_ins == 32'd0) w_table_next[0] = arp.key_note;
            for (int i = 1; i < NUM_SLOTS; i++) begin
                if (32'(i) == w_ins)     w_table_next[i] = arp.key_note;
                else if (32'(i) > w_ins) w_table_next[i] = r_table[i-1];
            end
            w_count_next = r_count + CountWidth'(1);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_counter_next   = r_counter;
        w_idx_next       = r_idx;
        w_oct_next       = r_oct;
        w_dir_next       = r_dir;
        w_prev_mode_next = r_prev_mode;
        w_note_next      = r_note;
        w_gate_next      = r_gate;
        w_updn_dir       = 1'b0;
        w_nxt            = '0;
        w_sel            = '0;
        w_sum            = '0;
        if (r_count == '0) begin
            w_state_next   = StIdle;
            w_counter_next = '0;
            w_idx_next     = '0;
            w_oct_next     = 1'b0;
            w_dir_next     = 1'b0;
            w_gate_next    = 1'b0;
        end else begin
            w_counter_next = (w_cnt + 32'd1 >= w_p) ? '0 : RATE_WIDTH'(w_cnt + 32'd1);
            if (r_counter == '0) begin
                w_oct_next = 1'b0;
                if (r_state == StIdle) begin
                    w_nxt      = (arp.mode == 2'd1) ? w_n - 32'd1 : 32'd0;
                    w_dir_next = 1'b0;
                end else begin
                    case (arp.mode)
                        2'd0: w_nxt = (w_idx + 32'd1 >= w_n) ? 32'd0 : w_idx + 32'd1;
                        2'd1: w_nxt = (w_idx == 32'd0 || w_idx >= w_n) ? w_n - 32'd1
                                                                        : w_idx - 32'd1;
                        2'd2: begin
                            // Direction restarts ascending when up-down is newly selected.
                            w_updn_dir = (r_prev_mode == 2'd2) ? r_dir : 1'b0;
                            if (w_n == 32'd1) begin
                                w_nxt      = 32'd0;
                                w_dir_next = 1'b0;
                            end else if (!w_updn_dir) begin
                                w_dir_next = !(w_idx + 32'd1 < w_n);
                                w_nxt      = w_dir_next ? w_n - 32'd2 : w_idx + 32'd1;
                            end else if (w_idx == 32'd0) begin
                                w_nxt      = 32'd1;
                                w_dir_next = 1'b0;
                            end else begin
                                w_nxt      = (w_idx >= w_n) ? w_n - 32'd1 : w_idx - 32'd1;
                                w_dir_next = 1'b1;
                            end
                        end
                        default: begin
                            if (w_idx + 32'd1 >= w_n) begin
                                w_nxt      = 32'd0;
                                w_oct_next = !r_oct;
                            end else begin
                                w_nxt      = w_idx + 32'd1;
                                w_oct_next = r_oct;
                            end
                        end
                    endcase
                end
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (32'(i) == w_nxt) w_sel = r_table[i];
                end
                w_sum            = 32'(w_sel) + (w_oct_next ? 32'd12 : 32'd0);
                w_note_next      = (w_sum > 32'd127) ? 7'd127 : w_sum[6:0];
                w_gate_next      = 1'b1;
                w_idx_next       = IdxWidth'(w_nxt);
                w_prev_mode_next = arp.mode;
                w_state_next     = StRun;
            end else if (w_cnt == w_g) begin
                w_gate_next = 1'b0;
            end
        end
    end

    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            r_table     <= '{default: '0};
            r_count     <= '0;
            r_state     <= StIdle;
            r_counter   <= '0;
            r_idx       <= '0;
            r_oct       <= 1'b0;
            r_dir       <= 1'b0;
            r_prev_mode <= '0;
            r_note      <= '0;
            r_gate      <= 1'b0;
        end else begin
            r_table     <= w_table_next;
            r_count     <= w_count_next;
            r_state     <= w_state_next;
            r_counter   <= w_counter_next;
            r_idx       <= w_idx_next;
            r_oct       <= w_oct_next;
            r_dir       <= w_dir_next;
            r_prev_mode <= w_prev_mode_next;
            r_note      <= w_note_next;
            r_gate      <= w_gate_next;
        end
    end

    assign arp.note       = r_note;
    assign arp.gate       = r_gate;
    assign arp.held_count = r_count;
    assign arp.full       = w_full;
endmodule
